// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32 integer core (FETCH/DECODE/EXECUTE/MEM/WRITEBACK) on one shared req/ready memory port.
// Define RISCV_MC_ILLEGAL_TRAP_EN to halt on unsupported instructions; otherwise they retire as NOPs.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NREGS      = 32,
  parameter int          MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           ALUOut,
  output logic [31:0]           WriteData,
  output logic [31:0]           PC,
  output logic                  retire,
  output logic                  halted
);
  localparam int RW = (NREGS == 16) ? 4 : 5;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT   = 3'd5;
`endif

  logic [2:0]            state_q, state_d;
  logic [31:0]           pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]           alu_q, alu_d, mdr_q, mdr_d, wd_q, wd_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d, addr_full;
  logic                  rf_we, retire_c, mem_ok;
  logic [31:0]           rf [NREGS];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [RW-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;
  logic [31:0] op_b, alu_res, rs1_val, rs2_val;
  logic is_r, is_ialu, is_lui, is_lw, is_sw, is_br, is_jal, is_jalr, illegal, br_taken;

  assign opc     = ir_q[6:0];
  assign f3      = ir_q[14:12];
  assign f7      = ir_q[31:25];
  assign rd_idx  = ir_q[7 +: RW];
  assign rs1_idx = ir_q[15 +: RW];
  assign rs2_idx = ir_q[20 +: RW];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;

  assign is_r    = (opc == 7'b0110011) &&
                   (((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
                    ((f7 == 7'b0100000) && (f3 == 3'b000)));
  assign is_ialu = (opc == 7'b0010011) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
  assign is_lui  = (opc == 7'b0110111);
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_br   = (opc == 7'b1100011) && (f3[2:1] == 2'b00);
  assign is_jal  = (opc == 7'b1101111);
  assign is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);
  assign illegal = !(is_r || is_ialu || is_lui || is_lw || is_sw || is_br || is_jal || is_jalr);

  assign rs1_val  = (rs1_idx == '0) ? 32'd0 : rf[rs1_idx];
  assign rs2_val  = (rs2_idx == '0) ? 32'd0 : rf[rs2_idx];
  assign op_b     = (is_r || is_br) ? b_q : (is_sw ? imm_s : imm_i);
  assign br_taken = f3[0] ? (a_q != b_q) : (a_q == b_q);
  assign mem_ok   = mem_req_q && mem_ready;

  always_comb begin
    alu_res = a_q + op_b;
    if (is_r || is_ialu) begin
      case (f3)
        3'b111:  alu_res = a_q & op_b;
        3'b110:  alu_res = a_q | op_b;
        3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(op_b)};
        default: alu_res = (is_r && f7[5]) ? (a_q - op_b) : (a_q + op_b);
      endcase
    end
  end

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    wd_d     = wd_q;
    rf_we    = 1'b0;
    retire_c = 1'b0;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    halted_d = halted_q;
`endif
    case (state_q)
      S_FETCH: if (mem_ok) begin
        ir_d    = mem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (illegal) begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
          halted_d = 1'b1;
          state_d  = S_HALT;
`else
          pc_d     = pc_plus4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
`endif
        end else if (is_br) begin
          pc_d     = br_taken ? (pc_q + imm_b) : pc_plus4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: if (mem_ok) begin
        if (is_lw) begin
          mdr_d   = mem_rdata;
          state_d = S_WB;
        end else begin
          pc_d     = pc_plus4;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_WB: begin
        wd_d = is_lw ? mdr_q : (is_jal || is_jalr) ? pc_plus4 : is_lui ? imm_u : alu_q;
        pc_d = is_jal ? (pc_q + imm_j) : is_jalr ? (alu_q & ~32'd1) : pc_plus4;
        rf_we    = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  // Port outputs are registered from next state so they stay glitch-free and stable across wait cycles.
  always_comb begin
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && is_sw;
    addr_full   = (state_d == S_MEM) ? alu_d : pc_d;
    mem_addr_d  = mem_req_d ? {addr_full[MEM_ADDR_W-1:2], 2'b00} : mem_addr_q;
    mem_wdata_d = mem_we_d ? b_q : mem_wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rf_we && (rd_idx != '0)) rf[rd_idx] <= wd_d;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ALUOut    = alu_q;
  assign WriteData = wd_q;
  assign PC        = pc_q;
  assign retire    = retire_c;
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed program run on riscv_multicycle_core: per-instruction next PC, WriteData and cycle count.
`timescale 1ns/1ps
module tb_riscv_multicycle_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ALUOut, WriteData, PC;

  int checks = 0;
  int failures = 0;
  int wcnt = 0;
  int data_wait = 3;
  logic [31:0] mem [0:1023];

  logic [31:0] exp_pc [21];
  logic [31:0] exp_wd [21];
  int          exp_cpi [21];

  always #5 clk = ~clk;

  riscv_multicycle_core #(.RESET_PC(32'h100), .NREGS(32), .MEM_ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ALUOut(ALUOut), .WriteData(WriteData), .PC(PC), .retire(retire), .halted(halted)
  );

  // Data region below 0x20 answers after data_wait extra cycles; code answers at once.
  assign mem_rdata = mem[mem_addr[11:2]];
  assign mem_ready = mem_req && (wcnt >= ((mem_addr < 32'h20) ? data_wait : 0));

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      wcnt <= 0;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_retire(input int limit, output logic got, output int n);
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      @(negedge clk);
      n++;
      got = retire;
    end
  endtask

  logic got;
  int   n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem['h100 >> 2] = 32'h00500093; // addi x1,x0,5
    mem['h104 >> 2] = 32'h00700113; // addi x2,x0,7
    mem['h108 >> 2] = 32'h002081B3; // add  x3,x1,x2
    mem['h10C >> 2] = 32'h40208233; // sub  x4,x1,x2
    mem['h110 >> 2] = 32'h00302423; // sw   x3,8(x0)
    mem['h114 >> 2] = 32'h00802283; // lw   x5,8(x0)
    mem['h118 >> 2] = 32'h00122333; // slt  x6,x4,x1
    mem['h11C >> 2] = 32'h00A0E393; // ori  x7,x1,10
    mem['h120 >> 2] = 32'h0021F433; // and  x8,x3,x2
    mem['h124 >> 2] = 32'h123454B7; // lui  x9,0x12345
    mem['h128 >> 2] = 32'hFFF0A513; // slti x10,x1,-1
    mem['h12C >> 2] = 32'h00317593; // andi x11,x2,3
    mem['h130 >> 2] = 32'h00900013; // addi x0,x0,9
    mem['h134 >> 2] = 32'h00100633; // add  x12,x0,x1
    mem['h138 >> 2] = 32'h00109863; // bne  x1,x1,+16
    mem['h13C >> 2] = 32'h00C0006F; // jal  x0,+12
    mem['h140 >> 2] = 32'h0100006F; // jal  x0,+16
    mem['h148 >> 2] = 32'hFE108CE3; // beq  x1,x1,-8
    mem['h150 >> 2] = 32'hED1FF06F; // jal  x0,-0x130
    mem['h20 >> 2]  = 32'h010000EF; // jal  x1,+16
    mem['h30 >> 2]  = 32'h00308067; // jalr x0,3(x1)
    mem['h24 >> 2]  = 32'hFFFFFFFF; // illegal, fetched from PC 0x26
    mem['h28 >> 2]  = 32'h0000006F; // jal  x0,0

    exp_pc  = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h120,
                32'h124, 32'h128, 32'h12C, 32'h130, 32'h134, 32'h138, 32'h13C, 32'h148,
                32'h140, 32'h150, 32'h20,  32'h30,  32'h26};
    exp_wd  = '{32'h5, 32'h7, 32'hC, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hC, 32'h1, 32'hF,
                32'h4, 32'h12345000, 32'h0, 32'h3, 32'h9, 32'h5, 32'h5, 32'h140,
                32'h140, 32'h144, 32'h154, 32'h24, 32'h34};
    exp_cpi = '{0, 4, 4, 4, 7, 8, 4, 4, 4, 4, 4, 4, 4, 4, 3, 4, 3, 4, 4, 4, 4};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_aluout", ALUOut, 32'd0);
    check("rst_writedata", WriteData, 32'd0);
    check("rst_pc", PC, 32'h100);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h100);
    check("first_we", {31'd0, mem_we}, 32'd0);

    for (int k = 0; k < 21; k++) begin
      wait_retire(40, got, n);
      check($sformatf("retire_%0d", k), {31'd0, got}, 32'd1);
      if (k > 0) check($sformatf("cpi_%0d", k), n, exp_cpi[k]);
      @(posedge clk);
      #1;
      check($sformatf("pc_%0d", k), PC, exp_pc[k]);
      check($sformatf("wd_%0d", k), WriteData, exp_wd[k]);
      if (k == 4) check("store_word", mem[2], 32'hC);
    end

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    wait_retire(20, got, n);
    check("halt_no_retire", {31'd0, got}, 32'd0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_no_req", {31'd0, mem_req}, 32'd0);
    check("halt_pc", PC, 32'h26);
`else
    wait_retire(40, got, n);
    check("nop_retire", {31'd0, got}, 32'd1);
    check("nop_cpi", n, 32'd3);
    @(posedge clk);
    #1;
    check("nop_pc", PC, 32'h2A);
    check("nop_halted", {31'd0, halted}, 32'd0);
`endif

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_pc", PC, 32'h100);
    check("arst_halted", {31'd0, halted}, 32'd0);
    check("arst_wd", WriteData, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("restart_req", {31'd0, mem_req}, 32'd1);
    check("restart_addr", mem_addr, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
